// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the SPI-driven capture controller: opcodes, FSM states,
// status-byte layout and the fixed MISO filler bytes.
package capture_ctrl_pkg;

  typedef enum logic [7:0] {
    CMD_START      = 8'h01,
    CMD_STOP       = 8'h02,
    CMD_SET_REDUCE = 8'h03,
    CMD_STATUS     = 8'h10,
    CMD_READ       = 8'h20
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ARG     = 3'd2,
    ST_STATUS  = 3'd3,
    ST_READ    = 3'd4,
    ST_DISCARD = 3'd5
  } state_t;

  localparam int STAT_BIT_CAPTURE  = 7;
  localparam int STAT_BIT_OVERFLOW = 6;
  localparam int STAT_BIT_FULL     = 5;
  localparam int STAT_BIT_EMPTY    = 4;

  localparam logic [7:0] TX_IDLE_BYTE = 8'h00;
  localparam logic [7:0] TX_ERR_BYTE  = 8'hFF;

endpackage

// File: rtl/capture_ctrl.sv
// Byte-command controller between the SPI slave, the I2S capture path and the
// sample FIFO read port. READ streams FIFO words with one-word prefetch.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int FIFO_WIDTH     = 8,
  parameter int COUNT_WIDTH    = 21,
  parameter int REDUCE_WIDTH   = 4,
  parameter int DEFAULT_REDUCE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_cs_active,
  input  logic                    spi_rx_valid,
  input  logic [7:0]              spi_rx_data,
  output logic [7:0]              spi_tx_data,
  output logic                    fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0]   fifo_rd_data,
  input  logic                    fifo_empty,
  input  logic                    fifo_full,
  input  logic [COUNT_WIDTH-1:0]  fifo_count,
  output logic                    capture_en,
  output logic [REDUCE_WIDTH-1:0] reduce_factor,
  output logic                    overflow
);

  state_t                  state;
  logic                    cs_prev;
  logic                    rd_pend;     // popped word arrives this cycle
  logic                    tx_fifo;     // spi_tx_data holds a FIFO word not yet shifted out
  logic                    hold_valid;
  logic [7:0]              hold;
  logic [23:0]             stat_sr;
  logic [7:0]              status_flags;
  logic [REDUCE_WIDTH-1:0] arg_reduce;
  logic                    cs_rise, cs_fall, read_byte;

  assign cs_rise   = spi_cs_active && !cs_prev;
  assign cs_fall   = !spi_cs_active && cs_prev;
  assign read_byte = spi_rx_valid &&
                     ((state == ST_CMD && spi_rx_data == CMD_READ) || state == ST_READ);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    status_flags                    = '0;
    status_flags[STAT_BIT_CAPTURE]  = capture_en;
    status_flags[STAT_BIT_OVERFLOW] = overflow;
    status_flags[STAT_BIT_FULL]     = fifo_full;
    status_flags[STAT_BIT_EMPTY]    = fifo_empty;
    arg_reduce = spi_rx_data[REDUCE_WIDTH-1:0];
    if (arg_reduce == '0) arg_reduce = REDUCE_WIDTH'(1);
  end

  // NOTE: state is updated with non-blocking assignments only; later assignments in the
  // block deliberately override earlier ones (READ prefetch, overflow set, frame end).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cs_prev       <= 1'b1;  // a frame already open at reset is not seen as a new one
      rd_pend       <= 1'b0;
      tx_fifo       <= 1'b0;
      hold_valid    <= 1'b0;
      hold          <= '0;
      stat_sr       <= '0;
      spi_tx_data   <= TX_IDLE_BYTE;
      fifo_rd_en    <= 1'b0;
      capture_en    <= 1'b0;
      reduce_factor <= REDUCE_WIDTH'(DEFAULT_REDUCE);
      overflow      <= 1'b0;
    end else begin
      cs_prev    <= spi_cs_active;
      fifo_rd_en <= 1'b0;
      rd_pend    <= fifo_rd_en;

      // A word popped after the frame closed is parked for the next READ.
      if (rd_pend) begin
        if (spi_cs_active) begin
          spi_tx_data <= 8'(fifo_rd_data);
          tx_fifo     <= 1'b1;
        end else begin
          hold       <= 8'(fifo_rd_data);
          hold_valid <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: if (cs_rise) begin
          state       <= ST_CMD;
          spi_tx_data <= TX_IDLE_BYTE;
          tx_fifo     <= 1'b0;
        end
        ST_CMD: if (spi_rx_valid) begin
          state       <= ST_DISCARD;
          spi_tx_data <= TX_IDLE_BYTE;
          tx_fifo     <= 1'b0;
          case (spi_rx_data)
            CMD_START: begin
              capture_en <= 1'b1;
              overflow   <= 1'b0;
            end
            CMD_STOP:       capture_en <= 1'b0;
            CMD_SET_REDUCE: state <= ST_ARG;
            CMD_STATUS: begin
              state       <= ST_STATUS;
              spi_tx_data <= status_flags;
              stat_sr     <= 24'(fifo_count);
            end
            CMD_READ:       state <= ST_READ;
            default:        spi_tx_data <= TX_ERR_BYTE;
          endcase
        end
        ST_ARG: if (spi_rx_valid) begin
          reduce_factor <= arg_reduce;
          state         <= ST_DISCARD;
        end
        ST_STATUS: if (spi_rx_valid) begin
          spi_tx_data <= stat_sr[23:16];
          stat_sr     <= {stat_sr[15:0], 8'h00};
        end
        default: ;
      endcase

      if (read_byte) begin
        if (hold_valid) begin
          if (spi_cs_active) begin
            spi_tx_data <= hold;
            hold_valid  <= 1'b0;
            tx_fifo     <= 1'b1;
          end
        end else if (!fifo_empty && !fifo_rd_en) begin
          fifo_rd_en <= 1'b1;
          tx_fifo    <= 1'b0;
        end else begin
          spi_tx_data <= TX_IDLE_BYTE;
          tx_fifo     <= 1'b0;
        end
      end

      if (cs_fall) begin
        state   <= ST_IDLE;
        tx_fifo <= 1'b0;
        // The prefetched byte never reached MISO; keep it for the next READ.
        if (state == ST_READ && !spi_rx_valid && tx_fifo && !fifo_rd_en && !rd_pend) begin
          hold       <= spi_tx_data;
          hold_valid <= 1'b1;
        end
      end

      if (fifo_full && capture_en) overflow <= 1'b1;
    end
  end

endmodule
